// File: rtl/strlen_controller.sv
// Measures a null-terminated byte string in word-addressed 64-bit memory, one word per read.
// Optional macro STRLEN_CYCLE_COUNT_EN adds a 32-bit cycle_count output counting busy cycles.
module strlen_controller #(
    parameter int ADDR_W    = 16,
    parameter int LEN_W     = 16,
    parameter int MAX_WORDS = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              busy,
    output logic              done,
    output logic [LEN_W-1:0]  str_len,
    output logic              error,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [63:0]       mem_rdata,
    input  logic              mem_rvalid
`ifdef STRLEN_CYCLE_COUNT_EN
    ,
    output logic [31:0]       cycle_count
`endif
);

    localparam int CNT_W = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(MAX_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DONE
    } state_t;

    state_t           state;
    logic [LEN_W-1:0] acc;
    logic [CNT_W-1:0] count;
    logic [3:0]       word_len;

    // Non-null bytes counted from the least-significant byte; 8 means no terminator in this word.
    function automatic logic [3:0] length_finder(input logic [63:0] word);
        logic [3:0] n;
        logic       hit;
        n   = 4'd8;
        hit = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (!hit && word[8*i +: 8] == 8'h00) begin
                n   = 4'(i);
                hit = 1'b1;
            end
        end
        return n;
    endfunction

    assign word_len = length_finder(mem_rdata);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            str_len   <= '0;
            error     <= 1'b0;
            mem_rd_en <= 1'b0;
            mem_addr  <= '0;
            acc       <= '0;
            count     <= '0;
        end else begin
            done      <= 1'b0;
            mem_rd_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        mem_addr  <= base_addr;
                        acc       <= '0;
                        count     <= '0;
                        error     <= 1'b0;
                        busy      <= 1'b1;
                        mem_rd_en <= 1'b1;
                        state     <= REQ;
                    end
                end
                REQ: begin
                    state <= WAIT;
                end
                WAIT: begin
                    if (mem_rvalid) begin
                        if (word_len != 4'd8) begin
                            str_len <= acc + LEN_W'(word_len);
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            state   <= DONE;
                        end else if (count == LAST_WORD) begin
                            // Word budget exhausted with no terminator seen.
                            str_len <= acc + LEN_W'(8);
                            error   <= 1'b1;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            state   <= DONE;
                        end else begin
                            acc       <= acc + LEN_W'(8);
                            count     <= count + CNT_W'(1);
                            mem_addr  <= mem_addr + ADDR_W'(1);
                            mem_rd_en <= 1'b1;
                            state     <= REQ;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef STRLEN_CYCLE_COUNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_count <= '0;
        end else if (state == IDLE && start) begin
            cycle_count <= '0;
        end else if (busy) begin
            cycle_count <= cycle_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_strlen_controller.sv
// Bench for strlen_controller: directed vector table, reset corner sequences and
// randomized strings checked against a byte-level reference model.
module tb_strlen_controller;

    localparam int MAXW = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] base_addr;
    logic        busy;
    logic        done;
    logic [15:0] str_len;
    logic        error;
    logic        mem_rd_en;
    logic [15:0] mem_addr;
    logic [63:0] mem_rdata;
    logic        mem_rvalid;
`ifdef STRLEN_CYCLE_COUNT_EN
    logic [31:0] cycle_count;
`endif

    strlen_controller #(
        .ADDR_W(16),
        .LEN_W(16),
        .MAX_WORDS(MAXW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .base_addr(base_addr),
        .busy(busy),
        .done(done),
        .str_len(str_len),
        .error(error),
        .mem_rd_en(mem_rd_en),
        .mem_addr(mem_addr),
        .mem_rdata(mem_rdata),
        .mem_rvalid(mem_rvalid)
`ifdef STRLEN_CYCLE_COUNT_EN
        ,
        .cycle_count(cycle_count)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    bit [63:0] mem [0:65535];
    int        mem_lat = 1;

    typedef struct {
        logic [15:0] addr;
        int          due;
    } req_t;

    req_t        pq[$];
    logic [15:0] rd_log[$];

    int errors = 0;
    int checks = 0;

    // Memory: a request seen in cycle c is answered in cycle c + mem_lat.
    initial begin : responder
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        forever begin
            @(negedge clk);
            mem_rvalid = 1'b0;
            if (pq.size() > 0 && pq[0].due == cyc) begin
                mem_rdata  = mem[pq[0].addr];
                mem_rvalid = 1'b1;
                void'(pq.pop_front());
            end
            if (mem_rd_en === 1'b1) begin
                pq.push_back('{mem_addr, cyc + mem_lat});
                rd_log.push_back(mem_addr);
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", nm, act, exp);
        end
    endtask

    // Reference: walk the string byte by byte from base, at most MAXW words.
    task automatic model(input logic [15:0] base, output int len, output bit err, output int words);
        bit          found;
        logic [15:0] a;
        logic [7:0]  b;
        found = 1'b0;
        len   = MAXW * 8;
        err   = 1'b1;
        words = MAXW;
        for (int i = 0; i < MAXW * 8; i++) begin
            a = base + 16'(i / 8);
            b = mem[a][8*(i%8) +: 8];
            if (!found && b == 8'h00) begin
                found = 1'b1;
                len   = i;
                err   = 1'b0;
                words = i / 8 + 1;
            end
        end
    endtask

    task automatic run(input logic [15:0] base, input int lat, input bit inject,
                       input int exp_len, input bit exp_err, input int exp_w, input string nm);
        int          s;
        int          t;
        bit          busy_ok;
        bit          addr_ok;
        logic [15:0] held;
        mem_lat = lat;
        rd_log.delete();
        @(negedge clk);
        base_addr = base;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        s         = cyc;
        base_addr = ~base;
        check({nm, " first read"}, mem_rd_en, 1'b1);
        check({nm, " first addr"}, mem_addr, base);
        check({nm, " error cleared"}, error, 1'b0);
        t       = 0;
        busy_ok = 1'b1;
        while (done !== 1'b1 && t < 400) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            @(negedge clk);
            t++;
            start = inject && (t == 1);
        end
        start = 1'b0;
        if (done !== 1'b1) begin
            check({nm, " done timeout"}, 1'b0, 1'b1);
        end else begin
            check({nm, " busy until done"}, busy_ok, 1'b1);
            check({nm, " latency"}, cyc - s, exp_w * (lat + 1));
            check({nm, " str_len"}, str_len, exp_len);
            check({nm, " error"}, error, exp_err);
            check({nm, " busy at done"}, busy, 1'b0);
            check({nm, " reads"}, rd_log.size(), exp_w);
            addr_ok = 1'b1;
            foreach (rd_log[i]) if (rd_log[i] !== base + 16'(i)) addr_ok = 1'b0;
            check({nm, " read addrs"}, addr_ok, 1'b1);
`ifdef STRLEN_CYCLE_COUNT_EN
            check({nm, " cycle_count"}, cycle_count, exp_w * (lat + 1));
`endif
            held = str_len;
            @(negedge clk);
            check({nm, " done one cycle"}, done, 1'b0);
            check({nm, " str_len held"}, str_len, exp_len);
            if (held !== str_len) check({nm, " str_len stable"}, str_len, held);
        end
    endtask

    typedef struct {
        logic [15:0]      base;
        int               lat;
        logic [3:0][63:0] w;
        int               len;
        bit               err;
        int               words;
        bit               inject;
    } vec_t;

    vec_t tbl[7];

    task automatic random_phase();
        logic [15:0] b;
        logic [15:0] a;
        logic [63:0] word;
        int          tgt;
        int          lat;
        int          p;
        int          el;
        bit          ee;
        int          ew;
        for (int k = 0; k < 24; k++) begin
            b   = 16'($urandom);
            tgt = $urandom_range(0, 35);
            lat = $urandom_range(1, 4);
            for (int w = 0; w < MAXW; w++) begin
                for (int j = 0; j < 8; j++) begin
                    p = w * 8 + j;
                    if (p < tgt) word[8*j +: 8] = 8'($urandom_range(1, 255));
                    else if (p == tgt) word[8*j +: 8] = 8'h00;
                    else word[8*j +: 8] = 8'($urandom);
                end
                a = b + 16'(w);
                mem[a] = word;
            end
            model(b, el, ee, ew);
            run(b, lat, 1'b0, el, ee, ew, $sformatf("rand%0d", k));
        end
    endtask

    task automatic reset_phase();
        int  n0;
        bit  rd_seen;
        bit  done_seen;
        bit  busy_seen;
        // Long string in flight; reset lands while the controller waits on memory.
        mem[16'h0100] = 64'h1111_2222_3333_4444;
        mem[16'h0101] = 64'h0;
        mem_lat = 4;
        rd_log.delete();
        @(negedge clk);
        base_addr = 16'h0100;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst busy", busy, 1'b0);
        check("rst done", done, 1'b0);
        check("rst str_len", str_len, 16'h0);
        check("rst error", error, 1'b0);
        check("rst rd_en", mem_rd_en, 1'b0);
        check("rst addr", mem_addr, 16'h0);
        rd_seen   = 1'b0;
        done_seen = 1'b0;
        busy_seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (mem_rd_en !== 1'b0) rd_seen = 1'b1;
            if (done !== 1'b0) done_seen = 1'b1;
            if (busy !== 1'b0) busy_seen = 1'b1;
        end
        check("rst no read", rd_seen, 1'b0);
        check("rst no done", done_seen, 1'b0);
        check("rst idle", busy_seen, 1'b0);
        check("rst late resp consumed", pq.size(), 0);
        check("rst read count", rd_log.size(), 1);

        n0 = rd_log.size();
        @(negedge clk);
        start = 1'b1;
        reset = 1'b1;
        base_addr = 16'h0100;
        @(negedge clk);
        start = 1'b0;
        reset = 1'b0;
        check("start+reset busy", busy, 1'b0);
        check("start+reset rd_en", mem_rd_en, 1'b0);
        repeat (3) @(negedge clk);
        check("start+reset no read", rd_log.size(), n0);
    endtask

    initial begin : main
        reset     = 1'b1;
        start     = 1'b0;
        base_addr = '0;
        repeat (3) @(negedge clk);
        check("reset busy", busy, 1'b0);
        check("reset done", done, 1'b0);
        check("reset str_len", str_len, 16'h0);
        check("reset error", error, 1'b0);
        check("reset rd_en", mem_rd_en, 1'b0);
        check("reset addr", mem_addr, 16'h0);
        reset = 1'b0;
        // Unsolicited response in IDLE must do nothing.
        @(negedge clk);
        mem_rvalid = 1'b1;
        @(negedge clk);
        check("idle rvalid busy", busy, 1'b0);
        check("idle rvalid done", done, 1'b0);

        tbl[0] = '{16'h0010, 1, {64'h0, 64'h0, 64'h0, 64'hAABBCCDDEEFF00AA}, 1, 1'b0, 1, 1'b0};
        tbl[1] = '{16'h0020, 3, {64'h0, 64'h0, 64'h00BBCCDDEE44FFAA, 64'hAABBCCDDEEFFAA99}, 15, 1'b0, 2, 1'b0};
        tbl[2] = '{16'h0030, 2, {64'h0, 64'h0, 64'h0, 64'hAABBCCDDEEFFAA00}, 0, 1'b0, 1, 1'b0};
        tbl[3] = '{16'h0040, 1, {64'h0, 64'h0, 64'h0, 64'h0}, 0, 1'b0, 1, 1'b0};
        tbl[4] = '{16'h0050, 2, {64'h44BBC00DEE44FFAA, 64'h44BBC00DEE44FFAA,
                                64'h44BBC00DEE44FFAA, 64'h44BBC00DEE44FFAA}, 32, 1'b1, 4, 1'b0};
        tbl[5] = '{16'h0060, 1, {64'h0000000000112233, 64'h0102030405060708,
                                64'h1112131415161718, 64'h2122232425262728}, 27, 1'b0, 4, 1'b0};
        tbl[6] = '{16'hFFFF, 2, {64'h0, 64'h0, 64'hAABBCC00EE00FFAA, 64'h1122334455667788}, 10, 1'b0, 2, 1'b1};

        for (int v = 0; v < 7; v++) begin
            for (int i = 0; i < 4; i++) mem[tbl[v].base + 16'(i)] = tbl[v].w[i];
            run(tbl[v].base, tbl[v].lat, tbl[v].inject, tbl[v].len, tbl[v].err,
                tbl[v].words, $sformatf("vec%0d", v));
        end

        random_phase();

        // Leave a non-zero length and a set error flag before the reset sequences.
        run(16'h0050, 1, 1'b0, 32, 1'b1, 4, "pre-reset overflow");
        reset_phase();
        run(16'h0020, 2, 1'b0, 15, 1'b0, 2, "after reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
